// File: rtl/pic_pkg.sv
// Shared PIC definitions: acknowledge FSM states, IR level count, spurious level.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pic_pkg;

  localparam int IR_COUNT = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Encodings are fixed so state values match older register dumps.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } pic_state_e;

  // One-hot strobe for an IR level.
  function automatic logic [IR_COUNT-1:0] level_onehot(input logic [2:0] lvl);
    level_onehot = IR_COUNT'(1) << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority resolver (IR0 highest): picks the best request above the in-service level.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [IR_COUNT-1:0] irr_masked,
  input  logic [IR_COUNT-1:0] isr,
  output logic [2:0]          winner,
  output logic                winner_vld
);

  logic [IR_COUNT-1:0] isr_lowest;
  logic [IR_COUNT-1:0] allow_mask;
  logic [IR_COUNT-1:0] qualifying;

  // Only levels strictly above the highest-priority in-service bit may interrupt;
  // with ISR empty the subtraction wraps to all ones, so every level qualifies.
  assign isr_lowest = isr & (~isr + IR_COUNT'(1));
  assign allow_mask = isr_lowest - IR_COUNT'(1);
  assign qualifying = irr_masked & allow_mask;

  // Priority encode: the lowest-numbered qualifying level wins.
  always_comb begin
    winner     = 3'd0;
    winner_vld = 1'b0;
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      if (qualifying[i]) begin
        winner     = 3'(i);
        winner_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// INTA-cycle controller: raises INT, latches the winner on the first INTA, drives the vector on the second.
// Latency: INT one cycle after a qualifying request; ISR_set one cycle after the INTA falling edge.
// Backpressure: none; the CPU paces the sequence via INTA_n. Build macro PIC_AEOI_EN enables ISR_clear.
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                INTA_n,
  input  logic [IR_COUNT-1:0] IRR_masked,
  input  logic [IR_COUNT-1:0] ISR,
  input  logic [4:0]          ICW2_T,
  input  logic                Address_Write_Enable,
  output logic [2:0]          Interrupt_Location,
  output logic                interruptExists,
  output logic                INT,
  output logic [IR_COUNT-1:0] ISR_set,
  output logic [IR_COUNT-1:0] ISR_clear,
  output logic [7:0]          D_out,
  output logic                D_out_en
);

  pic_state_e state;
  logic       inta_d;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] win_lvl;
  logic       win_vld;

  pic_priority_resolver u_resolver (
    .irr_masked (IRR_masked),
    .isr        (ISR),
    .winner     (win_lvl),
    .winner_vld (win_vld)
  );

  // Delayed INTA_n for edge detection; idles high so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inta_d <= 1'b1;
    else       inta_d <= INTA_n;
  end

  assign inta_fall = inta_d & ~INTA_n;
  assign inta_rise = ~inta_d & INTA_n;

  // Acknowledge FSM and its registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      INT                <= 1'b0;
      interruptExists    <= 1'b0;
      Interrupt_Location <= 3'd0;
      ISR_set            <= '0;
      D_out              <= 8'h00;
      D_out_en           <= 1'b0;
    end else begin
      ISR_set <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= PEND;
            INT   <= 1'b1;
          end
        end
        PEND: begin
          // The acknowledge edge takes precedence over a request vanishing in the
          // same cycle; that combination is the spurious case.
          if (inta_fall) begin
            state           <= ACK1;
            interruptExists <= 1'b1;
            if (win_vld) begin
              Interrupt_Location <= win_lvl;
              ISR_set            <= level_onehot(win_lvl);
            end else begin
              Interrupt_Location <= SPURIOUS_LEVEL;
            end
          end else if (!win_vld) begin
            state <= IDLE;
            INT   <= 1'b0;
          end
        end
        ACK1: begin
          if (inta_rise) begin
            state <= GAP;
            INT   <= 1'b0;
          end
        end
        GAP: begin
          if (inta_fall) begin
            state <= ACK2;
            D_out <= {ICW2_T, Interrupt_Location};
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state           <= IDLE;
            interruptExists <= 1'b0;
            D_out_en        <= 1'b0;
          end else begin
            D_out_en <= Address_Write_Enable;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIC_AEOI_EN
  logic spurious;

  // Automatic EOI: retire the served level as the second INTA ends, unless spurious.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spurious  <= 1'b0;
      ISR_clear <= '0;
    end else begin
      ISR_clear <= '0;
      if (state == PEND && inta_fall)
        spurious <= ~win_vld;
      if (state == ACK2 && inta_rise && !spurious)
        ISR_clear <= level_onehot(Interrupt_Location);
    end
  end
`else
  assign ISR_clear = '0;
`endif

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer: normal, nested, spurious, slave-driven and reset cases.
// Latency: outputs sampled 1 ns after each rising clock edge.
// Backpressure: none; INTA_n is driven directly by the stimulus.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       INTA_n;
  logic [7:0] IRR_masked;
  logic [7:0] ISR;
  logic [4:0] ICW2_T;
  logic       Address_Write_Enable;
  logic [2:0] Interrupt_Location;
  logic       interruptExists;
  logic       INT;
  logic [7:0] ISR_set;
  logic [7:0] ISR_clear;
  logic [7:0] D_out;
  logic       D_out_en;

  int checks   = 0;
  int failures = 0;

`ifdef PIC_AEOI_EN
  localparam bit AEOI = 1'b1;
`else
  localparam bit AEOI = 1'b0;
`endif

  interrupt_ack_sequencer dut (
    .clk                  (clk),
    .reset                (reset),
    .INTA_n               (INTA_n),
    .IRR_masked           (IRR_masked),
    .ISR                  (ISR),
    .ICW2_T               (ICW2_T),
    .Address_Write_Enable (Address_Write_Enable),
    .Interrupt_Location   (Interrupt_Location),
    .interruptExists      (interruptExists),
    .INT                  (INT),
    .ISR_set              (ISR_set),
    .ISR_clear            (ISR_clear),
    .D_out                (D_out),
    .D_out_en             (D_out_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; INTA_n = 1'b1; IRR_masked = 8'h00; ISR = 8'h00;
    ICW2_T = 5'b01000; Address_Write_Enable = 1'b0;
    tick(); tick();
    chk("rst_int",    {7'd0, INT}, 8'h00);
    chk("rst_exists", {7'd0, interruptExists}, 8'h00);
    chk("rst_loc",    {5'd0, Interrupt_Location}, 8'h00);
    chk("rst_set",    ISR_set, 8'h00);
    chk("rst_clear",  ISR_clear, 8'h00);
    chk("rst_dout",   D_out, 8'h00);
    chk("rst_douten", {7'd0, D_out_en}, 8'h00);
    reset = 1'b0;
    tick();

    // INTA falling edge while idle is ignored
    INTA_n = 1'b0; tick();
    chk("idle_inta_exists", {7'd0, interruptExists}, 8'h00);
    chk("idle_inta_set",    ISR_set, 8'h00);
    INTA_n = 1'b1; tick();

    // IR3, ISR empty: full sequence, vector 0x43
    IRR_masked = 8'h08; tick();
    chk("t1_int", {7'd0, INT}, 8'h01);
    INTA_n = 1'b0; tick();
    chk("t1_set",    ISR_set, 8'h08);
    chk("t1_loc",    {5'd0, Interrupt_Location}, 8'h03);
    chk("t1_exists", {7'd0, interruptExists}, 8'h01);
    tick();
    chk("t1_set_pulse", ISR_set, 8'h00);
    INTA_n = 1'b1; tick();
    chk("t1_int_drop", {7'd0, INT}, 8'h00);
    Address_Write_Enable = 1'b1; INTA_n = 1'b0; tick();
    tick();
    chk("t1_dout",   D_out, 8'h43);
    chk("t1_douten", {7'd0, D_out_en}, 8'h01);
    IRR_masked = 8'h00; INTA_n = 1'b1; tick();
    chk("t1_end_exists", {7'd0, interruptExists}, 8'h00);
    chk("t1_end_douten", {7'd0, D_out_en}, 8'h00);
    chk("t1_clear", ISR_clear, AEOI ? 8'h08 : 8'h00);
    tick();
    chk("t1_clear_pulse", ISR_clear, 8'h00);
    chk("t1_loc_held", {5'd0, Interrupt_Location}, 8'h03);

    // IRR 0x22 with IR2 in service: IR1 wins; slave drives vector (AWE=0)
    IRR_masked = 8'h22; ISR = 8'h04; tick();
    chk("t2_int", {7'd0, INT}, 8'h01);
    INTA_n = 1'b0; tick();
    chk("t2_set", ISR_set, 8'h02);
    chk("t2_loc", {5'd0, Interrupt_Location}, 8'h01);
    INTA_n = 1'b1; tick();
    Address_Write_Enable = 1'b0; INTA_n = 1'b0; tick();
    tick(); tick();
    chk("t2_douten", {7'd0, D_out_en}, 8'h00);
    chk("t2_exists", {7'd0, interruptExists}, 8'h01);
    chk("t2_loc_held", {5'd0, Interrupt_Location}, 8'h01);
    chk("t2_dout", D_out, 8'h41);
    IRR_masked = 8'h00; INTA_n = 1'b1; tick();
    chk("t2_clear", ISR_clear, AEOI ? 8'h02 : 8'h00);

    // IR0 in service blocks everything
    IRR_masked = 8'h22; ISR = 8'h01; tick(); tick();
    chk("t2b_int", {7'd0, INT}, 8'h00);
    IRR_masked = 8'h00; ISR = 8'h00; tick();

    // Spurious: request vanishes as INTA falls
    IRR_masked = 8'h10; tick();
    chk("t3_int", {7'd0, INT}, 8'h01);
    IRR_masked = 8'h00; INTA_n = 1'b0; tick();
    chk("t3_loc",    {5'd0, Interrupt_Location}, 8'h07);
    chk("t3_set",    ISR_set, 8'h00);
    chk("t3_exists", {7'd0, interruptExists}, 8'h01);
    INTA_n = 1'b1; tick();
    Address_Write_Enable = 1'b1; INTA_n = 1'b0; tick();
    tick();
    chk("t3_dout", D_out, 8'h47);
    INTA_n = 1'b1; tick();
    chk("t3_clear", ISR_clear, 8'h00);

    // IR5 sequence for automatic EOI
    IRR_masked = 8'h20; tick();
    INTA_n = 1'b0; tick();
    chk("t5_set", ISR_set, 8'h20);
    chk("t5_loc", {5'd0, Interrupt_Location}, 8'h05);
    INTA_n = 1'b1; tick();
    INTA_n = 1'b0; tick();
    IRR_masked = 8'h00; tick();
    chk("t5_dout", D_out, 8'h45);
    INTA_n = 1'b1; tick();
    chk("t5_clear", ISR_clear, AEOI ? 8'h20 : 8'h00);
    tick();
    chk("t5_clear_pulse", ISR_clear, 8'h00);

    // Reset asserted in GAP clears outputs asynchronously
    IRR_masked = 8'h04; tick();
    INTA_n = 1'b0; tick();
    chk("t6_set", ISR_set, 8'h04);
    INTA_n = 1'b1; tick();
    chk("t6_gap_exists", {7'd0, interruptExists}, 8'h01);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_exists", {7'd0, interruptExists}, 8'h00);
    chk("t6_rst_int",    {7'd0, INT}, 8'h00);
    chk("t6_rst_douten", {7'd0, D_out_en}, 8'h00);
    chk("t6_rst_set",    ISR_set, 8'h00);
    chk("t6_rst_clear",  ISR_clear, 8'h00);
    chk("t6_rst_loc",    {5'd0, Interrupt_Location}, 8'h00);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_int_after", {7'd0, INT}, 8'h01);
    INTA_n = 1'b0; tick();
    chk("t6_set_after", ISR_set, 8'h04);
    chk("t6_loc_after", {5'd0, Interrupt_Location}, 8'h02);
    INTA_n = 1'b1; tick();
    INTA_n = 1'b0; tick();
    IRR_masked = 8'h00; tick();
    chk("t6_dout_after", D_out, 8'h42);
    INTA_n = 1'b1; tick();
    chk("t6_end_exists", {7'd0, interruptExists}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
